evt_readout_ctrl: RTL and testbench

Sequences event readout for the pixel array. Round-robin selects a row with pending pixel requests, snapshots that row's column requests, then scans the columns in ascending order. Each pixel event goes out as a (row, column) address on a valid/ready handshake, and the originating pixel receives a one-cycle ack. Sits between the pixel request matrix and the downstream event packer/FIFO.

---
 rtl/evt_pkg.sv | 20 ++
 rtl/evt_rr_arb.sv | 44 ++++
 rtl/evt_readout_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_evt_readout_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_pkg.sv
// rtl/evt_pkg.sv - shared types and defaults for the event readout controller
//
// Purpose: FSM state type and default sizing constants used by
// evt_readout_ctrl and evt_rr_arb.
// Ports: none (package).
package evt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } evt_state_e;

  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 4;
  localparam int X_WIDTH_DEF  = 2;
  localparam int Y_WIDTH_DEF  = 2;
  localparam int TS_WIDTH_DEF = 16;

endpackage

// File: rtl/evt_rr_arb.sv
// rtl/evt_rr_arb.sv - N-way round-robin arbiter with external pointer
//
// Purpose: grants the first requester at or after ptr_i, wrapping at N.
// The pointer is owned by the caller so it can decide when priority moves.
// Ports:
//   req_i  [N-1:0]   request vector
//   ptr_i  [IW-1:0]  index of the highest-priority requester
//   gnt_o  [N-1:0]   one-hot grant (0 when no request)
//   idx_o  [IW-1:0]  index of the granted requester
//   any_o            at least one request present
module evt_rr_arb
  import evt_pkg::*;
#(
  parameter int N  = ROWS_DEF,
  parameter int IW = X_WIDTH_DEF
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int             cand;
  logic [IW-1:0]  cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand     = (int'(ptr_i) + i) % N;
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/evt_readout_ctrl.sv
// rtl/evt_readout_ctrl.sv - row/column event readout sequencer for the pixel array
//
// Purpose: round-robin picks a requesting row, snapshots its column
// requests, then emits one (row, column) event per pending column in
// ascending order on a valid/ready handshake, acking each pixel for one cycle.
// Optional build macro EVT_TIMESTAMP_EN adds a free-running timestamp that is
// captured with each event.
// Ports:
//   clk_i, reset_ni            clock, asynchronous active-low reset
//   enable_i                   allow a new row to be selected (sampled in IDLE)
//   req_i   [ROWS*COLS-1:0]    pixel request levels, bit r*COLS+c
//   evt_ready_i                downstream accepts the event
//   evt_valid_o                event address valid
//   evt_xadd_o [X_WIDTH-1:0]   event row
//   evt_yadd_o [Y_WIDTH-1:0]   event column
//   ack_o   [ROWS*COLS-1:0]    one-hot one-cycle pixel acknowledge
//   row_gnt_o [ROWS-1:0]       one-hot row being serviced, 0 when idle
//   busy_o                     controller not in IDLE
//   evt_ts_o [TS_WIDTH-1:0]    event timestamp (EVT_TIMESTAMP_EN only)
module evt_readout_ctrl
  import evt_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int X_WIDTH  = X_WIDTH_DEF,
  parameter int Y_WIDTH  = Y_WIDTH_DEF
`ifdef EVT_TIMESTAMP_EN
  ,
  parameter int TS_WIDTH = TS_WIDTH_DEF
`endif
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 enable_i,
  input  logic [ROWS*COLS-1:0] req_i,
  input  logic                 evt_ready_i,
  output logic                 evt_valid_o,
  output logic [X_WIDTH-1:0]   evt_xadd_o,
  output logic [Y_WIDTH-1:0]   evt_yadd_o,
  output logic [ROWS*COLS-1:0] ack_o,
  output logic [ROWS-1:0]      row_gnt_o,
  output logic                 busy_o
`ifdef EVT_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]  evt_ts_o
`endif
);

  evt_state_e             state_q, state_d;
  logic [X_WIDTH-1:0]     ptr_q, ptr_d;
  logic [X_WIDTH-1:0]     row_q, row_d;
  logic [ROWS-1:0]        row_gnt_q, row_gnt_d;
  logic [COLS-1:0]        col_pend_q, col_pend_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [X_WIDTH-1:0]     xadd_q, xadd_d;
  logic [Y_WIDTH-1:0]     yadd_q, yadd_d;
  logic [ROWS*COLS-1:0]   ack_q, ack_d;

  logic [ROWS-1:0]        row_req;
  logic [ROWS-1:0]        arb_gnt;
  logic [X_WIDTH-1:0]     arb_idx;
  logic                   arb_any;
  logic [COLS-1:0]        row_bits;
  logic [Y_WIDTH-1:0]     col_sel;

  always_comb begin
    row_req = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_req[r] = |req_i[r*COLS +: COLS];
    end
  end

  evt_rr_arb #(
    .N  (ROWS),
    .IW (X_WIDTH)
  ) u_row_arb (
    .req_i (row_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Column bits of the row the arbiter is granting, for the snapshot.
  always_comb begin
    row_bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (arb_gnt[r]) begin
        row_bits = req_i[r*COLS +: COLS];
      end
    end
  end

  // Lowest pending column wins: scan downwards so the last hit is the lowest.
  always_comb begin
    col_sel = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_pend_q[c]) begin
        col_sel = Y_WIDTH'(c);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    row_d       = row_q;
    row_gnt_d   = row_gnt_q;
    col_pend_d  = col_pend_q;
    evt_valid_d = evt_valid_q;
    xadd_d      = xadd_q;
    yadd_d      = yadd_q;
    ack_d       = '0;
    case (state_q)
      IDLE: begin
        if (enable_i && arb_any) begin
          row_gnt_d  = arb_gnt;
          row_d      = arb_idx;
          col_pend_d = row_bits;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (|col_pend_q) begin
          evt_valid_d = 1'b1;
          xadd_d      = row_q;
          yadd_d      = col_sel;
          state_d     = HOLD;
        end else begin
          // Row done: the next row after this one gets top priority.
          ptr_d     = (row_q == X_WIDTH'(ROWS - 1)) ? '0 : row_q + 1'b1;
          row_gnt_d = '0;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        if (evt_ready_i) begin
          evt_valid_d = 1'b0;
          for (int c = 0; c < COLS; c++) begin
            if (Y_WIDTH'(c) == yadd_q) begin
              col_pend_d[c] = 1'b0;
            end
          end
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if (X_WIDTH'(r) == xadd_q && Y_WIDTH'(c) == yadd_q) begin
                ack_d[r*COLS + c] = 1'b1;
              end
            end
          end
          state_d = SCAN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      row_q       <= '0;
      row_gnt_q   <= '0;
      col_pend_q  <= '0;
      evt_valid_q <= 1'b0;
      xadd_q      <= '0;
      yadd_q      <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      row_q       <= row_d;
      row_gnt_q   <= row_gnt_d;
      col_pend_q  <= col_pend_d;
      evt_valid_q <= evt_valid_d;
      xadd_q      <= xadd_d;
      yadd_q      <= yadd_d;
      ack_q       <= ack_d;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_xadd_o  = xadd_q;
  assign evt_yadd_o  = yadd_q;
  assign ack_o       = ack_q;
  assign row_gnt_o   = row_gnt_q;
  assign busy_o      = (state_q != IDLE);

`ifdef EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q;
  logic [TS_WIDTH-1:0] evt_ts_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts_cnt_q <= '0;
      evt_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      if (state_q == SCAN && state_d == HOLD) begin
        evt_ts_q <= ts_cnt_q;
      end
    end
  end

  assign evt_ts_o = evt_ts_q;
`endif

endmodule

// File: tb/tb_evt_readout_ctrl.sv
// tb/tb_evt_readout_ctrl.sv - self-checking bench for evt_readout_ctrl
module tb_evt_readout_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic        clk_i       = 1'b0;
  logic        reset_ni    = 1'b0;
  logic        enable_i    = 1'b0;
  logic [15:0] req_i       = '0;
  logic        evt_ready_i = 1'b0;
  logic        evt_valid_o;
  logic [1:0]  evt_xadd_o;
  logic [1:0]  evt_yadd_o;
  logic [15:0] ack_o;
  logic [3:0]  row_gnt_o;
  logic        busy_o;

  evt_readout_ctrl dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .enable_i    (enable_i),
    .req_i       (req_i),
    .evt_ready_i (evt_ready_i),
    .evt_valid_o (evt_valid_o),
    .evt_xadd_o  (evt_xadd_o),
    .evt_yadd_o  (evt_yadd_o),
    .ack_o       (ack_o),
    .row_gnt_o   (row_gnt_o),
    .busy_o      (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Model expectations, written only by the model thread.
  int          m_ptr     = 0;
  logic        exp_valid = 1'b0;
  logic [1:0]  exp_x     = '0;
  logic [1:0]  exp_y     = '0;
  logic [15:0] exp_ack   = '0;
  logic [3:0]  exp_gnt   = '0;
  logic        exp_busy  = 1'b0;

  // Requester behaviour: drop a request once acked, optionally re-raise later.
  bit          rerq_en   = 1'b0;
  logic [15:0] rerq_mask = '0;
  logic [15:0] rerq_next = '0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Behavioural readout model: one pass = pick a row, walk its snapshot.
  task automatic model_run();
    int row;
    int c;
    logic [COLS-1:0] pend;
    m_ptr = 0;
    exp_valid = 1'b0; exp_x = '0; exp_y = '0; exp_ack = '0; exp_gnt = '0; exp_busy = 1'b0;
    forever begin
      do begin
        @(posedge clk_i);
        if (!reset_ni) return;
        exp_ack = '0;
      end while (!(enable_i && req_i != 0));
      row = -1;
      for (int k = 0; k < ROWS; k++) begin
        int r;
        r = (m_ptr + k) % ROWS;
        if (row < 0 && req_i[r*COLS +: COLS] != 0) row = r;
      end
      pend     = req_i[row*COLS +: COLS];
      exp_gnt  = 4'(1 << row);
      exp_busy = 1'b1;
      forever begin
        @(posedge clk_i);
        if (!reset_ni) return;
        exp_ack = '0;
        if (pend == 0) begin
          m_ptr    = (row + 1) % ROWS;
          exp_gnt  = '0;
          exp_busy = 1'b0;
          break;
        end
        c = 0;
        while (!pend[c]) c++;
        exp_valid = 1'b1;
        exp_x     = 2'(row);
        exp_y     = 2'(c);
        do begin
          @(posedge clk_i);
          if (!reset_ni) return;
        end while (!evt_ready_i);
        exp_valid = 1'b0;
        exp_ack   = 16'(1 << (row*COLS + c));
        pend[c]   = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      wait (reset_ni === 1'b1);
      model_run();
    end
  end

  // Per-cycle compare against the model, then requester update.
  task automatic tick();
    @(negedge clk_i);
    chk("valid", 32'(evt_valid_o), reset_ni ? 32'(exp_valid) : 32'd0);
    chk("xadd",  32'(evt_valid_o ? evt_xadd_o : 2'd0), reset_ni ? 32'(exp_valid ? exp_x : 2'd0) : 32'd0);
    chk("yadd",  32'(evt_valid_o ? evt_yadd_o : 2'd0), reset_ni ? 32'(exp_valid ? exp_y : 2'd0) : 32'd0);
    chk("ack",   32'(ack_o),     reset_ni ? 32'(exp_ack)  : 32'd0);
    chk("gnt",   32'(row_gnt_o), reset_ni ? 32'(exp_gnt)  : 32'd0);
    chk("busy",  32'(busy_o),    reset_ni ? 32'(exp_busy) : 32'd0);
    #1;
    req_i     = req_i | rerq_next;
    rerq_next = '0;
    req_i     = req_i & ~ack_o;
    if (rerq_en) rerq_next = ack_o & rerq_mask;
  endtask

  logic [3:0]  grants[$];
  logic [3:0]  exp_seq [7];
  logic [15:0] acks[$];
  logic [3:0]  prev_gnt;
  logic [15:0] ack_or;
  int          n_acks;

  initial begin
    exp_seq = '{4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(evt_valid_o), 32'd0);
    chk("rst_ack",   32'(ack_o),       32'd0);
    chk("rst_gnt",   32'(row_gnt_o),   32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    reset_ni = 1'b1;

    // Single pixel (2,1)
    enable_i = 1'b1; evt_ready_i = 1'b1; req_i = 16'h0200;
    tick();
    chk("t2_gnt", 32'(row_gnt_o), 32'h4);
    chk("t2_valid_early", 32'(evt_valid_o), 32'd0);
    tick();
    chk("t2_valid", 32'(evt_valid_o), 32'd1);
    chk("t2_x", 32'(evt_xadd_o), 32'd2);
    chk("t2_y", 32'(evt_yadd_o), 32'd1);
    tick();
    chk("t2_ack", 32'(ack_o), 32'h0200);
    chk("t2_busy_still", 32'(busy_o), 32'd1);
    tick();
    chk("t2_ack_gone", 32'(ack_o), 32'd0);
    chk("t2_busy_low", 32'(busy_o), 32'd0);

    // Row 1, columns 0,2,3
    req_i = 16'h00D0;
    acks.delete();
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 7) chk("t3_gnt", 32'(row_gnt_o), 32'h2);
      if (ack_o != 0) acks.push_back(ack_o);
    end
    chk("t3_nacks", 32'(acks.size()), 32'd3);
    chk("t3_ack0", 32'(acks.size() > 0 ? acks[0] : 16'h0), 32'h0010);
    chk("t3_ack1", 32'(acks.size() > 1 ? acks[1] : 16'h0), 32'h0040);
    chk("t3_ack2", 32'(acks.size() > 2 ? acks[2] : 16'h0), 32'h0080);
    chk("t3_idle", 32'(busy_o), 32'd0);

    // Backpressure at (0,3)
    evt_ready_i = 1'b0; req_i = 16'h0008;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", 32'(evt_valid_o), 32'd1);
      chk("t5_hold_x", 32'(evt_xadd_o), 32'd0);
      chk("t5_hold_y", 32'(evt_yadd_o), 32'd3);
      chk("t5_hold_ack", 32'(ack_o), 32'd0);
    end
    evt_ready_i = 1'b1;
    tick();
    chk("t5_ack", 32'(ack_o), 32'h0008);
    tick();
    chk("t5_ack_once", 32'(ack_o), 32'd0);

    // Rows 0 and 3 keep re-requesting; row 1 joins later
    rerq_en = 1'b1; rerq_mask = 16'h1001; req_i = 16'h1001;
    grants.delete();
    prev_gnt = row_gnt_o;
    for (int i = 0; i < 80 && grants.size() < 7; i++) begin
      tick();
      if (row_gnt_o != 0 && prev_gnt == 0) begin
        grants.push_back(row_gnt_o);
        if (grants.size() == 4) req_i = req_i | 16'h0010;
      end
      prev_gnt = row_gnt_o;
    end
    chk("t4_ngrants", 32'(grants.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk("t4_grant_seq", 32'(i < grants.size() ? grants[i] : 4'h0), 32'(exp_seq[i]));
    end
    rerq_en = 1'b0; rerq_next = '0;
    for (int i = 0; i < 40 && !(req_i == 0 && busy_o == 1'b0); i++) tick();
    chk("t4_drained", 32'(req_i == 0 && busy_o == 1'b0), 32'd1);

    // Enable low in IDLE
    enable_i = 1'b0; req_i = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_valid", 32'(evt_valid_o), 32'd0);
      chk("t6_no_busy", 32'(busy_o), 32'd0);
    end
    // Enable dropped mid-row 0 after a fresh reset (pointer back at row 0)
    reset_ni = 1'b0;
    tick(); tick();
    reset_ni = 1'b1;
    tick();
    enable_i = 1'b1;
    tick();
    chk("t6_gnt_row0", 32'(row_gnt_o), 32'h1);
    enable_i = 1'b0;
    n_acks = 0; ack_or = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack_o != 0) n_acks++;
      ack_or = ack_or | ack_o;
    end
    chk("t6_nacks", 32'(n_acks), 32'd4);
    chk("t6_ack_bits", 32'(ack_or), 32'h000F);
    chk("t6_idle", 32'(busy_o), 32'd0);
    chk("t6_gnt_idle", 32'(row_gnt_o), 32'd0);

    // Reset while holding event (2,1)
    reset_ni = 1'b0;
    tick(); tick();
    req_i = 16'h0200; evt_ready_i = 1'b0; enable_i = 1'b1;
    reset_ni = 1'b1;
    tick(); tick();
    chk("t1_valid", 32'(evt_valid_o), 32'd1);
    chk("t1_x", 32'(evt_xadd_o), 32'd2);
    chk("t1_y", 32'(evt_yadd_o), 32'd1);
    tick(); tick();
    reset_ni = 1'b0;
    #1;
    chk("t1_async_valid", 32'(evt_valid_o), 32'd0);
    chk("t1_async_gnt", 32'(row_gnt_o), 32'd0);
    chk("t1_async_busy", 32'(busy_o), 32'd0);
    tick(); tick();
    chk("t1_no_ack", 32'(ack_o), 32'd0);
    reset_ni = 1'b1; evt_ready_i = 1'b1;
    tick(); tick();
    chk("t1_reserve_valid", 32'(evt_valid_o), 32'd1);
    chk("t1_reserve_x", 32'(evt_xadd_o), 32'd2);
    chk("t1_reserve_y", 32'(evt_yadd_o), 32'd1);
    tick();
    chk("t1_reserve_ack", 32'(ack_o), 32'h0200);
    tick();
    chk("t1_done", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
